// File: rtl/issue_unit_pkg.sv
// Shared issue/CDB definitions: CDB source codes, default unit latencies and
// the per-slot payload of the CDB reservation ring.
package issue_unit_pkg;

  typedef logic [1:0] cdb_src_t;

  localparam cdb_src_t CDB_SRC_INTA = 2'd0;
  localparam cdb_src_t CDB_SRC_INTB = 2'd1;
  localparam cdb_src_t CDB_SRC_LDST = 2'd2;
  localparam cdb_src_t CDB_SRC_MUL  = 2'd3;

  // Default latencies, shared with the execution units.
  localparam int unsigned INT_LAT        = 1;
  localparam int unsigned LDST_LAT_DEF   = 2;
  localparam int unsigned MUL_LAT_DEF    = 4;
  localparam int unsigned STARVE_MAX_DEF = 4;

  // One reservation-ring slot: CDB reserved, and by whom.
  typedef struct packed {
    logic     valid;
    cdb_src_t src;
  } slot_t;

endpackage

// File: rtl/issue_unit_if.sv
// Issue-queue / issue-unit / CDB handshake bundle.
//   master: issue queues side (drives ready + stall, observes grants + CDB)
//   slave : issue_unit side   (observes ready + stall, drives grants + CDB)
interface issue_unit_if;
  import issue_unit_pkg::*;

  logic     issueque_ready_int_A;
  logic     issueque_ready_int_B;
  logic     issueque_ready_ld_st;
  logic     issueque_ready_mul;
  logic     issue_stall;
  logic     issue_int_A;
  logic     issue_int_B;
  logic     issue_ld_st;
  logic     issue_mul;
  logic     cdb_valid;
  cdb_src_t cdb_src;

  modport master (
    output issueque_ready_int_A, issueque_ready_int_B, issueque_ready_ld_st,
           issueque_ready_mul, issue_stall,
    input  issue_int_A, issue_int_B, issue_ld_st, issue_mul, cdb_valid, cdb_src
  );

  modport slave (
    input  issueque_ready_int_A, issueque_ready_int_B, issueque_ready_ld_st,
           issueque_ready_mul, issue_stall,
    output issue_int_A, issue_int_B, issue_ld_st, issue_mul, cdb_valid, cdb_src
  );

endinterface

// File: rtl/issue_unit_rr_arb2.sv
// 2-way round-robin arbiter for the integer queues.
//   clock, reset : clock, synchronous active-high reset
//   req[0]/[1]   : queue A / queue B request
//   en           : grants allowed this cycle
//   gnt_c        : combinational one-hot grant
// The pointer favours A after reset and flips to the other queue after each grant.
module issue_rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt_c
);

  logic ptr_q;  // 0: A has priority, 1: B has priority

  always_comb begin
    gnt_c = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt_c = 2'b01;
        2'b10:   gnt_c = 2'b10;
        2'b11:   gnt_c = ptr_q ? 2'b10 : 2'b01;
        default: gnt_c = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset)         ptr_q <= 1'b0;
    else if (gnt_c[0]) ptr_q <= 1'b1;
    else if (gnt_c[1]) ptr_q <= 1'b0;
  end

endmodule

// File: rtl/issue_unit.sv
// Issue scheduler for int A, int B, ld/st and mul queues sharing one CDB.
//   clock, reset : clock, synchronous active-high reset
//   bus (slave)  : queue ready flags + stall in; grants (combinational) and
//                  registered cdb_valid/cdb_src out
// A reservation ring (slot k = CDB busy k cycles from now) keeps the
// fixed-latency units off each other's CDB cycles; starve counters stop mul
// from monopolising the ring.
module issue_unit
  import issue_unit_pkg::*;
#(
  parameter int unsigned LDST_LAT   = LDST_LAT_DEF,
  parameter int unsigned MUL_LAT    = MUL_LAT_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic    clock,
  input  logic    reset,
  issue_unit_if.slave bus
);

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  slot_t               slots_q [1:MUL_LAT];
  slot_t               slots_d [1:MUL_LAT];
  logic                cdb_valid_q, cdb_valid_d;
  cdb_src_t            cdb_src_q, cdb_src_d;
  logic [STARVE_W-1:0] cnt_int_q, cnt_int_d, cnt_ldst_q, cnt_ldst_d;
  logic                starved_int_q, starved_int_d, starved_ldst_q, starved_ldst_d;

  logic       grant_ok;
  logic [1:0] int_gnt;
  logic       int_any, int_ready, ldst_gnt, mul_gnt;

  // Grant logic
  assign grant_ok  = !reset && !bus.issue_stall;
  assign int_ready = bus.issueque_ready_int_A || bus.issueque_ready_int_B;
  assign int_any   = |int_gnt;
  assign ldst_gnt  = grant_ok && bus.issueque_ready_ld_st && !slots_q[LDST_LAT].valid;
  assign mul_gnt   = grant_ok && bus.issueque_ready_mul && !starved_int_q && !starved_ldst_q;

  issue_rr_arb2 u_int_arb (
    .clock (clock),
    .reset (reset),
    .req   ({bus.issueque_ready_int_B, bus.issueque_ready_int_A}),
    .en    (grant_ok && !slots_q[1].valid),
    .gnt_c (int_gnt)
  );

  assign bus.issue_int_A = int_gnt[0];
  assign bus.issue_int_B = int_gnt[1];
  assign bus.issue_ld_st = ldst_gnt;
  assign bus.issue_mul   = mul_gnt;
  assign bus.cdb_valid   = cdb_valid_q;
  assign bus.cdb_src     = cdb_src_q;

  // Ring shift plus new reservations; int results bypass the ring (latency 1).
  always_comb begin
    for (int unsigned k = 1; k < MUL_LAT; k++) begin
      slots_d[k] = slots_q[k+1];
      if (ldst_gnt && k == LDST_LAT - 1) slots_d[k] = '{valid: 1'b1, src: CDB_SRC_LDST};
    end
    slots_d[MUL_LAT] = '0;
    if (mul_gnt) slots_d[MUL_LAT-1] = '{valid: 1'b1, src: CDB_SRC_MUL};

    cdb_valid_d = slots_q[1].valid || int_any;
    cdb_src_d   = slots_q[1].src;
    if (int_gnt[0]) cdb_src_d = CDB_SRC_INTA;
    if (int_gnt[1]) cdb_src_d = CDB_SRC_INTB;
  end

  // Starvation tracking; frozen while stalled. While not stalled, a ready
  // class can only be denied by a reservation.
  always_comb begin
    cnt_int_d      = cnt_int_q;
    cnt_ldst_d     = cnt_ldst_q;
    starved_int_d  = starved_int_q;
    starved_ldst_d = starved_ldst_q;
    if (!bus.issue_stall) begin
      if (int_any || !int_ready)     cnt_int_d = '0;
      else if (cnt_int_q != STARVE_LIM) cnt_int_d = cnt_int_q + STARVE_W'(1);
      if (int_any)                   starved_int_d = 1'b0;
      else if (cnt_int_d == STARVE_LIM) starved_int_d = 1'b1;

      if (ldst_gnt || !bus.issueque_ready_ld_st) cnt_ldst_d = '0;
      else if (cnt_ldst_q != STARVE_LIM)         cnt_ldst_d = cnt_ldst_q + STARVE_W'(1);
      if (ldst_gnt)                      starved_ldst_d = 1'b0;
      else if (cnt_ldst_d == STARVE_LIM) starved_ldst_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned k = 1; k <= MUL_LAT; k++) slots_q[k] <= '0;
      cdb_valid_q    <= 1'b0;
      cdb_src_q      <= CDB_SRC_INTA;
      cnt_int_q      <= '0;
      cnt_ldst_q     <= '0;
      starved_int_q  <= 1'b0;
      starved_ldst_q <= 1'b0;
    end else begin
      for (int unsigned k = 1; k <= MUL_LAT; k++) slots_q[k] <= slots_d[k];
      cdb_valid_q    <= cdb_valid_d;
      cdb_src_q      <= cdb_src_d;
      cnt_int_q      <= cnt_int_d;
      cnt_ldst_q     <= cnt_ldst_d;
      starved_int_q  <= starved_int_d;
      starved_ldst_q <= starved_ldst_d;
    end
  end

  // A grant must never land on an already reserved CDB slot.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(int_any && slots_q[1].valid));
      assert (!(ldst_gnt && slots_q[LDST_LAT].valid));
      assert (!(mul_gnt && slots_q[MUL_LAT].valid));
    end
  end

endmodule

// File: tb/tb_issue_unit.sv
// Directed self-checking bench for issue_unit (LDST_LAT=2, MUL_LAT=4, STARVE_MAX=4).
// Cycle tN: inputs driven 1 time unit after the edge opening tN, outputs
// sampled 1 unit later. Vectors are {mul, ld_st, int_B, int_A}; CDB is {valid, src}.
module tb_issue_unit;
  import issue_unit_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  issue_unit_if bus ();

  issue_unit #(.LDST_LAT(2), .MUL_LAT(4), .STARVE_MAX(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, check grants and CDB, advance to the next cycle.
  task automatic cyc(input string tag, input logic [3:0] rdy, input logic st, input logic rs,
                     input logic [3:0] g_exp, input logic [2:0] c_exp);
    bus.issueque_ready_int_A = rdy[0];
    bus.issueque_ready_int_B = rdy[1];
    bus.issueque_ready_ld_st = rdy[2];
    bus.issueque_ready_mul   = rdy[3];
    bus.issue_stall          = st;
    reset                    = rs;
    #1;
    chk({tag, " grant"}, {bus.issue_mul, bus.issue_ld_st, bus.issue_int_B, bus.issue_int_A}, g_exp);
    chk({tag, " cdb"}, {1'b0, bus.cdb_valid, bus.cdb_src}, {1'b0, c_exp});
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.issueque_ready_int_A = 1'b0;
    bus.issueque_ready_int_B = 1'b0;
    bus.issueque_ready_ld_st = 1'b0;
    bus.issueque_ready_mul   = 1'b0;
    bus.issue_stall          = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    // Reset state: no grants under reset, CDB idle.
    #1;
    chk("rst grant", {bus.issue_mul, bus.issue_ld_st, bus.issue_int_B, bus.issue_int_A}, 4'b0000);
    chk("rst cdb", {1'b0, bus.cdb_valid, bus.cdb_src}, 4'b0000);

    // 1: A and B alternate, then a lone A is granted regardless of the pointer.
    do_reset();
    for (int t = 0; t < 6; t++)
      cyc($sformatf("t1.%0d", t), 4'b0011, 1'b0, 1'b0,
          (t % 2 == 1) ? 4'b0010 : 4'b0001,
          (t == 0) ? 3'b000 : {1'b1, 2'((t - 1) % 2)});
    cyc("t1.6", 4'b0011, 1'b0, 1'b0, 4'b0001, 3'b101);
    cyc("t1.7", 4'b0001, 1'b0, 1'b0, 4'b0001, 3'b100);
    cyc("t1.8", 4'b0000, 1'b0, 1'b0, 4'b0000, 3'b100);

    // 2: mul at t0 blocks int A at t3.
    do_reset();
    cyc("t2.0", 4'b1000, 1'b0, 1'b0, 4'b1000, 3'b000);
    cyc("t2.1", 4'b0000, 1'b0, 1'b0, 4'b0000, 3'b000);
    cyc("t2.2", 4'b0000, 1'b0, 1'b0, 4'b0000, 3'b000);
    cyc("t2.3", 4'b0001, 1'b0, 1'b0, 4'b0000, 3'b000);
    cyc("t2.4", 4'b0001, 1'b0, 1'b0, 4'b0001, 3'b111);
    cyc("t2.5", 4'b0000, 1'b0, 1'b0, 4'b0000, 3'b100);

    // 3: mul at t0 blocks ld/st at t2.
    do_reset();
    cyc("t3.0", 4'b1000, 1'b0, 1'b0, 4'b1000, 3'b000);
    cyc("t3.1", 4'b0000, 1'b0, 1'b0, 4'b0000, 3'b000);
    cyc("t3.2", 4'b0100, 1'b0, 1'b0, 4'b0000, 3'b000);
    cyc("t3.3", 4'b0100, 1'b0, 1'b0, 4'b0100, 3'b000);
    cyc("t3.4", 4'b0000, 1'b0, 1'b0, 4'b0000, 3'b111);
    cyc("t3.5", 4'b0000, 1'b0, 1'b0, 4'b0000, 3'b110);

    // 4: int starvation stops mul; A wins once the ring drains, mul resumes.
    do_reset();
    cyc("t4.0", 4'b1000, 1'b0, 1'b0, 4'b1000, 3'b000);
    cyc("t4.1", 4'b1000, 1'b0, 1'b0, 4'b1000, 3'b000);
    cyc("t4.2", 4'b1000, 1'b0, 1'b0, 4'b1000, 3'b000);
    cyc("t4.3", 4'b1001, 1'b0, 1'b0, 4'b1000, 3'b000);
    cyc("t4.4", 4'b1001, 1'b0, 1'b0, 4'b1000, 3'b111);
    cyc("t4.5", 4'b1001, 1'b0, 1'b0, 4'b1000, 3'b111);
    cyc("t4.6", 4'b1001, 1'b0, 1'b0, 4'b1000, 3'b111);
    cyc("t4.7", 4'b1001, 1'b0, 1'b0, 4'b0000, 3'b111);
    cyc("t4.8", 4'b1001, 1'b0, 1'b0, 4'b0000, 3'b111);
    cyc("t4.9", 4'b1001, 1'b0, 1'b0, 4'b0000, 3'b111);
    cyc("t4.10", 4'b1001, 1'b0, 1'b0, 4'b0001, 3'b111);
    cyc("t4.11", 4'b1000, 1'b0, 1'b0, 4'b1000, 3'b100);

    // 5: stall suppresses grants but the mul result still reaches the CDB.
    do_reset();
    cyc("t5.0", 4'b1000, 1'b0, 1'b0, 4'b1000, 3'b000);
    cyc("t5.1", 4'b1101, 1'b1, 1'b0, 4'b0000, 3'b000);
    cyc("t5.2", 4'b1101, 1'b1, 1'b0, 4'b0000, 3'b000);
    cyc("t5.3", 4'b1101, 1'b1, 1'b0, 4'b0000, 3'b000);
    cyc("t5.4", 4'b0000, 1'b0, 1'b0, 4'b0000, 3'b111);
    cyc("t5.5", 4'b0000, 1'b0, 1'b0, 4'b0000, 3'b000);

    // 6: reset after a mul grant discards its reservation.
    do_reset();
    cyc("t6.0", 4'b1000, 1'b0, 1'b0, 4'b1000, 3'b000);
    cyc("t6.1", 4'b1101, 1'b0, 1'b1, 4'b0000, 3'b000);
    for (int t = 2; t <= 6; t++)
      cyc($sformatf("t6.%0d", t), 4'b0000, 1'b0, 1'b0, 4'b0000, 3'b000);

    // 7: simultaneous int, ld/st and mul grants land on distinct CDB cycles.
    do_reset();
    cyc("t7.0", 4'b1101, 1'b0, 1'b0, 4'b1101, 3'b000);
    cyc("t7.1", 4'b0000, 1'b0, 1'b0, 4'b0000, 3'b100);
    cyc("t7.2", 4'b0000, 1'b0, 1'b0, 4'b0000, 3'b110);
    cyc("t7.3", 4'b0000, 1'b0, 1'b0, 4'b0000, 3'b000);
    cyc("t7.4", 4'b0000, 1'b0, 1'b0, 4'b0000, 3'b111);
    cyc("t7.5", 4'b0000, 1'b0, 1'b0, 4'b0000, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
